// File: rtl/bp_fe_fence_sequencer_if.sv
// Fence sequencer handshake bundle: controller request/done, I$ drain credits,
// and the per-set invalidate valid/yumi channel.
interface bp_fe_fence_sequencer_if #(
    parameter int sets_p = 64
);
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;

    logic                  fence_v_i;
    logic                  fence_ready_and_o;
    logic                  credits_empty_i;
    logic                  itlb_flush_v_o;
    logic                  inval_v_o;
    logic [lg_sets_lp-1:0] inval_set_o;
    logic                  inval_yumi_i;
    logic                  busy_o;
    logic                  done_v_o;

    modport master (
        output fence_v_i, credits_empty_i, inval_yumi_i,
        input  fence_ready_and_o, itlb_flush_v_o, inval_v_o, inval_set_o, busy_o, done_v_o
    );

    modport slave (
        input  fence_v_i, credits_empty_i, inval_yumi_i,
        output fence_ready_and_o, itlb_flush_v_o, inval_v_o, inval_set_o, busy_o, done_v_o
    );
endinterface

// File: rtl/bp_fe_fence_sequencer.sv
// Front-end fence sequencer: ITLB flush on accept, wait for I$ fills to drain,
// invalidate every I$ set in order, then pulse done.
//
// state   | meaning
// e_idle  | ready for a fence request; handshake flushes the ITLB
// e_drain | waiting for outstanding I$ engine requests to retire
// e_inval | presenting inval_set_o = counter until yumi, then next set
// e_done  | one-cycle completion pulse, back to idle
module bp_fe_fence_sequencer #(
    parameter int sets_p = 64   // icache_sets_p of the default processor config
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_fe_fence_sequencer_if.slave   fe_if
);
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam logic [lg_sets_lp-1:0] last_set_lp = lg_sets_lp'(sets_p - 1);

    typedef enum logic [1:0] {e_idle, e_drain, e_inval, e_done} state_e;

    state_e                state_r, state_n;
    logic [lg_sets_lp-1:0] cnt_r, cnt_n;
    logic                  ready_c, flush_c, inval_c, busy_c, done_c;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        ready_c = 1'b0;
        flush_c = 1'b0;
        inval_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_r)
            e_idle: begin
                ready_c = 1'b1;
                if (fe_if.fence_v_i) begin
                    flush_c = 1'b1;
                    state_n = e_drain;
                    cnt_n   = '0;
                end
            end
            e_drain: begin
                busy_c = 1'b1;
                if (fe_if.credits_empty_i) state_n = e_inval;
            end
            e_inval: begin
                busy_c  = 1'b1;
                inval_c = 1'b1;
                if (fe_if.inval_yumi_i) begin
                    if (cnt_r == last_set_lp) begin
                        state_n = e_done;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_r + lg_sets_lp'(1);
                    end
                end
            end
            e_done: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    // Outputs are held low for the whole reset cycle, whatever state is registered.
    assign fe_if.fence_ready_and_o = ready_c & ~reset_i;
    assign fe_if.itlb_flush_v_o    = flush_c & ~reset_i;
    assign fe_if.inval_v_o         = inval_c & ~reset_i;
    assign fe_if.inval_set_o       = reset_i ? '0 : cnt_r;
    assign fe_if.busy_o            = busy_c & ~reset_i;
    assign fe_if.done_v_o          = done_c & ~reset_i;

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_if.inval_yumi_i |-> fe_if.inval_v_o);

    a_inval_held: assert property (@(posedge clk_i) disable iff (reset_i)
        (fe_if.inval_v_o && !fe_if.inval_yumi_i) |=> (fe_if.inval_v_o && $stable(fe_if.inval_set_o)));

    a_done_single: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_if.done_v_o |=> !fe_if.done_v_o);
endmodule

// File: tb/tb_bp_fe_fence_sequencer.sv
// Bench for bp_fe_fence_sequencer: four builds (4, 64, 3, 1 sets) checked every
// cycle against a progress-based model, plus directed timing pins on the 4-set build.
module tb_bp_fe_fence_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [4];
    logic       fence_v [4];
    logic       credits [4];
    logic       yumi_en [4];
    logic       obs_ready [4];
    logic       obs_flush [4];
    logic       obs_inval [4];
    logic       obs_busy  [4];
    logic       obs_done  [4];
    logic [5:0] obs_set   [4];

    int checks = 0;
    int errors = 0;
    int done_cnt [4] = '{default: 0};

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s inst=%0d t=%0t got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int sets_lp = (g == 0) ? 4 : (g == 1) ? 64 : (g == 2) ? 3 : 1;

        bp_fe_fence_sequencer_if #(.sets_p(sets_lp)) ifc ();
        bp_fe_fence_sequencer #(.sets_p(sets_lp)) dut (
            .clk_i   (clk),
            .reset_i (rst[g]),
            .fe_if   (ifc)
        );

        assign ifc.fence_v_i       = fence_v[g];
        assign ifc.credits_empty_i = credits[g];
        assign ifc.inval_yumi_i    = ifc.inval_v_o & yumi_en[g];
        assign obs_ready[g] = ifc.fence_ready_and_o;
        assign obs_flush[g] = ifc.itlb_flush_v_o;
        assign obs_inval[g] = ifc.inval_v_o;
        assign obs_busy[g]  = ifc.busy_o;
        assign obs_done[g]  = ifc.done_v_o;
        assign obs_set[g]   = 6'(ifc.inval_set_o);

        // Model: a fence is in flight, has (or has not) seen the drain, and has
        // handed out next_set invalidates; all sets handed out means completion.
        bit armed = 1'b0, in_fence = 1'b0, drained = 1'b0;
        int next_set = 0, walked = 0;
        bit e_act, e_ready, e_flush, e_busy, e_inval, e_done;
        int e_set;

        always @(negedge clk) begin
            if (rst[g]) armed = 1'b1;
            if (armed) begin
                e_act   = !rst[g];
                e_ready = e_act && !in_fence;
                e_flush = e_ready && fence_v[g];
                e_busy  = e_act && in_fence;
                e_inval = e_busy && drained && (next_set < sets_lp);
                e_done  = e_busy && drained && (next_set == sets_lp);
                e_set   = e_inval ? next_set : 0;
                chk("ready", g, obs_ready[g], e_ready);
                chk("flush", g, obs_flush[g], e_flush);
                chk("busy",  g, obs_busy[g],  e_busy);
                chk("inval_v", g, obs_inval[g], e_inval);
                chk("inval_set", g, obs_set[g], e_set);
                chk("done", g, obs_done[g], e_done);
                if (e_done) begin
                    chk("walk_len", g, walked, sets_lp);
                    done_cnt[g]++;
                end
                if (obs_inval[g] && yumi_en[g] && !rst[g]) walked++;
                if (rst[g]) begin
                    in_fence = 1'b0; drained = 1'b0; next_set = 0; walked = 0;
                end else if (!in_fence) begin
                    if (fence_v[g]) begin
                        in_fence = 1'b1; drained = 1'b0; next_set = 0; walked = 0;
                    end
                end else if (!drained) begin
                    drained = credits[g];
                end else if (next_set < sets_lp) begin
                    if (yumi_en[g]) next_set++;
                end else begin
                    in_fence = 1'b0;
                end
            end
        end
    end

    initial begin
        bit f_t[20], i_t[20], d_t[20], r_t[20], b_t[20];
        int s_t[20];
        int q[$];
        int n, first;

        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b1; fence_v[g] = 1'b0; credits[g] = 1'b0; yumi_en[g] = 1'b0;
        end
        @(negedge clk);
        chk("reset_ready", 0, obs_ready[0], 0);
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) rst[g] = 1'b0;

        // Latency: accept at cycle 0, sets 0..3 at cycles 2..5, done at 6, ready at 7.
        @(posedge clk); #1;
        fence_v[0] = 1'b1; credits[0] = 1'b1; yumi_en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            f_t[k] = obs_flush[0]; i_t[k] = obs_inval[0]; d_t[k] = obs_done[0];
            r_t[k] = obs_ready[0]; s_t[k] = int'(obs_set[0]);
            @(posedge clk); #1;
            if (k == 0) fence_v[0] = 1'b0;
        end
        chk("lat_flush_c0", 0, f_t[0], 1);
        chk("lat_inval_c1", 0, i_t[1], 0);
        for (int k = 2; k <= 5; k++) begin
            chk("lat_inval_v", 0, i_t[k], 1);
            chk("lat_inval_set", 0, s_t[k], k - 2);
        end
        chk("lat_inval_c6", 0, i_t[6], 0);
        chk("lat_done_c6", 0, d_t[6], 1);
        n = 0;
        for (int k = 0; k < 10; k++) n += d_t[k];
        chk("lat_done_count", 0, n, 1);
        chk("lat_ready_c6", 0, r_t[6], 0);
        chk("lat_ready_c7", 0, r_t[7], 1);

        // Drain hold: credits low through cycle 10, high from cycle 11.
        credits[0] = 1'b0; fence_v[0] = 1'b1;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_t[k] = obs_inval[0]; b_t[k] = obs_busy[0];
            if (obs_inval[0] && first < 0) first = k;
            @(posedge clk); #1;
            if (k == 0) fence_v[0] = 1'b0;
            if (k == 10) credits[0] = 1'b1;
        end
        n = 0;
        for (int k = 0; k <= 11; k++) n += i_t[k];
        chk("drain_no_inval", 0, n, 0);
        chk("drain_busy_c11", 0, b_t[11], 1);
        chk("drain_first_inval", 0, first, 12);

        // Held request: the accept/drain/4 sets/done sequence spans 7 cycles,
        // so the next accept lands on the 8th cycle of each round.
        fence_v[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (obs_flush[0]) q.push_back(k);
            @(posedge clk); #1;
        end
        fence_v[0] = 1'b0;
        chk("held_accepts", 0, q.size(), 4);
        for (int i = 0; i < q.size() && i < 4; i++) chk("held_spacing", 0, q[i], 7 * i);
        repeat (10) @(posedge clk);
        #1;

        // Reset while set 2 is presented; the next fence restarts at set 0.
        fence_v[0] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            f_t[k] = obs_flush[0]; i_t[k] = obs_inval[0]; d_t[k] = obs_done[0];
            r_t[k] = obs_ready[0]; b_t[k] = obs_busy[0]; s_t[k] = int'(obs_set[0]);
            @(posedge clk); #1;
            if (k == 0) fence_v[0] = 1'b0;
            if (k == 3) yumi_en[0] = 1'b0;
            if (k == 4) rst[0] = 1'b1;
            if (k == 5) begin rst[0] = 1'b0; yumi_en[0] = 1'b1; end
            if (k == 6) fence_v[0] = 1'b1;
            if (k == 7) fence_v[0] = 1'b0;
        end
        chk("rst_set_before", 0, s_t[4], 2);
        chk("rst_inval_before", 0, i_t[4], 1);
        chk("rst_outputs_zero", 0, {r_t[5], f_t[5], i_t[5], b_t[5], d_t[5], 27'(s_t[5])}, 0);
        chk("rst_idle_ready", 0, {r_t[6], b_t[6], i_t[6]}, 3'b100);
        n = 0;
        for (int k = 0; k < 11; k++) n += d_t[k];
        chk("rst_no_done", 0, n, 0);
        chk("rst_restart_flush", 0, f_t[7], 1);
        chk("rst_restart_set0", 0, {i_t[9], 6'(s_t[9])}, 7'b1000000);
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic on all builds, ~30% yumi acceptance, rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) begin
                fence_v[g] = ($urandom_range(0, 3) != 0);
                credits[g] = ($urandom_range(0, 1) != 0);
                yumi_en[g] = ($urandom_range(0, 9) < 3);
                rst[g]     = ($urandom_range(0, 999) == 0);
            end
        end
        @(posedge clk); #1;
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b0; fence_v[g] = 1'b0; credits[g] = 1'b1; yumi_en[g] = 1'b1;
        end
        repeat (100) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("dones_seen", g, (done_cnt[g] > 0), 1);
            chk("final_idle", g, {obs_ready[g], obs_busy[g]}, 2'b10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
